// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: parameter defaults and the memory arbiter state enum.
package cpu_pkg;

   localparam int unsigned DEF_ADDR_W  = 16;
   localparam int unsigned DEF_DATA_W  = 16;
   localparam int unsigned DEF_MEM_LAT = 4;

   // Latency counter width; holds MEM_LAT values up to 15.
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_e;

endpackage : cpu_pkg

// File: rtl/lat_counter.sv
// Loadable down-counter with zero flag, used to time the memory read latency.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (count -> 0)
//   load      - load load_val (has priority over dec)
//   load_val  - value to load
//   dec       - decrement by one; saturates at zero
//   zero_c    - combinational flag, count == 0
module lat_counter
   import cpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero_c
);

   logic [CNT_W-1:0] count;

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !zero_c) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero_c = (count == '0);

endmodule : lat_counter

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a unified single-port memory
// with fixed read latency. One access in flight; alternating priority on conflict.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   if_req/if_addr -> if_rdata/if_valid         - fetch port
//   dm_req/dm_wr/dm_addr/dm_wdata -> dm_rdata/dm_valid - data port
//   drain -> quiesced                 - block new grants; quiesced when idle
//   mem_en/mem_wr/mem_addr/mem_wdata, mem_rdata - memory side
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_req,
   input  logic              dm_wr,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   input  logic              drain,
   output logic              quiesced,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e state_q, state_d;

   // Owner of the current/most recent grant; doubles as the last-grant flag (1 = dm).
   logic last_dm_q;
   logic grant_c;
   logic grant_dm_c;
   logic capture_c;
   logic cnt_zero_c;

   // Latency timer: loaded on grant so it reads MEM_LAT in the first ACCESS cycle.
   lat_counter u_lat_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (grant_c),
      .load_val (CNT_W'(MEM_LAT)),
      .dec      (state_q == ST_ACCESS),
      .zero_c   (cnt_zero_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, grant and capture decisions
   always_comb begin
      state_d    = state_q;
      grant_c    = 1'b0;
      grant_dm_c = 1'b0;
      capture_c  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!drain && (if_req || dm_req)) begin
               grant_c    = 1'b1;
               // dm wins a conflict unless it also took the previous grant.
               grant_dm_c = dm_req && (!if_req || !last_dm_q);
               state_d    = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_zero_c) begin
               capture_c = 1'b1;
               state_d   = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered memory-side strobes, response pulses and data
   always_ff @(posedge clk) begin
      if (rst) begin
         last_dm_q <= 1'b0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_valid  <= 1'b0;
         dm_valid  <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         mem_en   <= grant_c;
         if_valid <= capture_c && !last_dm_q;
         dm_valid <= capture_c && last_dm_q;
         if (grant_c) begin
            last_dm_q <= grant_dm_c;
            mem_wr    <= grant_dm_c && dm_wr;
            mem_addr  <= grant_dm_c ? dm_addr : if_addr;
            mem_wdata <= grant_dm_c ? dm_wdata : '0;
         end
         // Read data lands in the owner's register; writes leave both untouched.
         if (capture_c && !mem_wr) begin
            if (last_dm_q) begin
               dm_rdata <= mem_rdata;
            end else begin
               if_rdata <= mem_rdata;
            end
         end
      end
   end

   assign quiesced = (state_q == ST_IDLE) && drain;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LAT=4 and a latency-accurate memory model
// returning addr ^ 16'hA5B5 for reads.
module tb_mem_arbiter;

   localparam int unsigned MEM_LAT = 4;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [15:0] if_addr;
   logic [15:0] if_rdata;
   logic        if_valid;
   logic        dm_req;
   logic        dm_wr;
   logic [15:0] dm_addr;
   logic [15:0] dm_wdata;
   logic [15:0] dm_rdata;
   logic        dm_valid;
   logic        drain;
   logic        quiesced;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   int checks;
   int errors;

   mem_arbiter #(
      .ADDR_W  (16),
      .DATA_W  (16),
      .MEM_LAT (MEM_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_valid  (if_valid),
      .dm_req    (dm_req),
      .dm_wr     (dm_wr),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_valid  (dm_valid),
      .drain     (drain),
      .quiesced  (quiesced),
      .mem_en    (mem_en),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: read data appears exactly MEM_LAT cycles after mem_en, junk otherwise.
   logic [MEM_LAT-1:0] rd_pipe;
   logic [15:0]        addr_pipe [MEM_LAT];

   always @(posedge clk) begin
      rd_pipe      <= {rd_pipe[MEM_LAT-2:0], mem_en & ~mem_wr};
      addr_pipe[0] <= mem_addr;
      for (int i = 1; i < int'(MEM_LAT); i++) begin
         addr_pipe[i] <= addr_pipe[i-1];
      end
   end

   assign mem_rdata = rd_pipe[MEM_LAT-1] ? (addr_pipe[MEM_LAT-1] ^ 16'hA5B5) : 16'hDEAD;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      clk      = 1'b0;
      rst      = 1'b1;
      if_req   = 1'b0;
      if_addr  = '0;
      dm_req   = 1'b0;
      dm_wr    = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      drain    = 1'b0;
      rd_pipe  = '0;

      // Reset state
      tick(2);
      chk("rst_mem_en",   16'(mem_en),   16'h0);
      chk("rst_if_valid", 16'(if_valid), 16'h0);
      chk("rst_dm_valid", 16'(dm_valid), 16'h0);
      chk("rst_if_rdata", if_rdata,      16'h0000);
      chk("rst_dm_rdata", dm_rdata,      16'h0000);
      chk("rst_mem_addr", mem_addr,      16'h0000);
      chk("rst_quiesced", 16'(quiesced), 16'h0);
      rst = 1'b0;
      tick(1);

      // Lone fetch
      if_req  = 1'b1;
      if_addr = 16'h0010;
      tick(1);
      chk("f_mem_en_c1",  16'(mem_en),   16'h1);
      chk("f_mem_wr_c1",  16'(mem_wr),   16'h0);
      chk("f_addr_c1",    mem_addr,      16'h0010);
      tick(1);
      chk("f_mem_en_c2",  16'(mem_en),   16'h0);
      tick(3);
      chk("f_valid_c5",   16'(if_valid), 16'h0);
      tick(1);
      chk("f_valid_c6",   16'(if_valid), 16'h1);
      chk("f_rdata_c6",   if_rdata,      16'hA5A5);
      chk("f_dmvalid_c6", 16'(dm_valid), 16'h0);
      if_req = 1'b0;
      tick(1);
      chk("f_valid_c7",   16'(if_valid), 16'h0);
      tick(1);
      chk("f_mem_en_c8",  16'(mem_en),   16'h0);

      // Simultaneous requests: dm first, then if
      if_req  = 1'b1;
      if_addr = 16'h0020;
      dm_req  = 1'b1;
      dm_wr   = 1'b0;
      dm_addr = 16'h2000;
      tick(1);
      chk("c_addr_c1",    mem_addr,      16'h2000);
      chk("c_mem_en_c1",  16'(mem_en),   16'h1);
      tick(5);
      chk("c_dmvalid_c6", 16'(dm_valid), 16'h1);
      chk("c_dmrdata_c6", dm_rdata,      16'h85B5);
      chk("c_ifvalid_c6", 16'(if_valid), 16'h0);
      dm_req = 1'b0;
      tick(2);
      chk("c_mem_en_c8",  16'(mem_en),   16'h1);
      chk("c_addr_c8",    mem_addr,      16'h0020);
      tick(5);
      chk("c_ifvalid_c13", 16'(if_valid), 16'h1);
      chk("c_ifrdata_c13", if_rdata,      16'hA595);
      chk("c_dmrdata_hold", dm_rdata,     16'h85B5);
      if_req = 1'b0;
      tick(1);

      // Continuous conflict: dm, if, dm, if
      if_req  = 1'b1;
      if_addr = 16'h0030;
      dm_req  = 1'b1;
      dm_addr = 16'h3000;
      tick(1);
      chk("alt_g0_en",   16'(mem_en), 16'h1);
      chk("alt_g0_addr", mem_addr,    16'h3000);
      for (int k = 1; k < 4; k++) begin
         tick(7);
         chk("alt_gk_en",   16'(mem_en), 16'h1);
         chk("alt_gk_addr", mem_addr,    (k % 2 == 1) ? 16'h0030 : 16'h3000);
      end
      tick(5);
      chk("alt_ifvalid", 16'(if_valid), 16'h1);
      chk("alt_ifrdata", if_rdata,      16'hA585);
      chk("alt_dmrdata", dm_rdata,      16'h95B5);
      if_req = 1'b0;
      dm_req = 1'b0;
      tick(1);

      // dm write
      dm_req   = 1'b1;
      dm_wr    = 1'b1;
      dm_addr  = 16'h0040;
      dm_wdata = 16'h1234;
      tick(1);
      chk("w_mem_en",  16'(mem_en), 16'h1);
      chk("w_mem_wr",  16'(mem_wr), 16'h1);
      chk("w_addr",    mem_addr,    16'h0040);
      chk("w_wdata",   mem_wdata,   16'h1234);
      tick(5);
      chk("w_dmvalid", 16'(dm_valid), 16'h1);
      chk("w_dmrdata", dm_rdata,      16'h95B5);
      dm_req = 1'b0;
      dm_wr  = 1'b0;
      tick(1);

      // Reset during a read
      dm_req  = 1'b1;
      dm_addr = 16'h5000;
      tick(3);
      rst = 1'b1;
      tick(1);
      chk("r_mem_en",   16'(mem_en),   16'h0);
      chk("r_mem_wr",   16'(mem_wr),   16'h0);
      chk("r_mem_addr", mem_addr,      16'h0000);
      chk("r_wdata",    mem_wdata,     16'h0000);
      chk("r_dmvalid",  16'(dm_valid), 16'h0);
      chk("r_if_rdata", if_rdata,      16'h0000);
      chk("r_dm_rdata", dm_rdata,      16'h0000);
      rst    = 1'b0;
      dm_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick(1);
         chk("r_no_valid", 16'(dm_valid | if_valid), 16'h0);
      end
      if_req  = 1'b1;
      if_addr = 16'h0060;
      tick(1);
      chk("r_new_en",     16'(mem_en), 16'h1);
      chk("r_new_addr",   mem_addr,    16'h0060);
      tick(5);
      chk("r_new_valid",  16'(if_valid), 16'h1);
      chk("r_new_rdata",  if_rdata,      16'hA5D5);
      if_req = 1'b0;
      tick(1);

      // Drain during a read with fetch pending
      dm_req  = 1'b1;
      dm_addr = 16'h7000;
      if_req  = 1'b1;
      if_addr = 16'h0070;
      tick(2);
      drain = 1'b1;
      chk("d_quiesced_c2", 16'(quiesced), 16'h0);
      tick(4);
      chk("d_dmvalid",     16'(dm_valid), 16'h1);
      chk("d_dmrdata",     dm_rdata,      16'hD5B5);
      dm_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick(1);
         chk("d_quiesced", 16'(quiesced), 16'h1);
         chk("d_no_mem_en", 16'(mem_en),  16'h0);
      end
      drain = 1'b0;
      tick(1);
      chk("d_resume_en",   16'(mem_en),   16'h1);
      chk("d_resume_addr", mem_addr,      16'h0070);
      chk("d_resume_q",    16'(quiesced), 16'h0);
      tick(5);
      chk("d_ifvalid",     16'(if_valid), 16'h1);
      chk("d_ifrdata",     if_rdata,      16'hA5C5);
      if_req = 1'b0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width.
REQ-002 Parameter DATA_W, default 16, data width.
REQ-003 Parameter MEM_LAT, default 4, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..15.
REQ-004 clk  input  1  system clock; one clock domain, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 if_req  input  1  instruction-fetch request; held with if_addr stable until if_valid.
REQ-007 if_addr  input  ADDR_W  fetch address.
REQ-008 if_rdata  output  DATA_W  fetched word; valid when if_valid=1.
REQ-009 if_valid  output  1  one-cycle fetch completion pulse.
REQ-010 dm_req  input  1  data-memory request; held with dm_wr/dm_addr/dm_wdata stable until dm_valid.
REQ-011 dm_wr  input  1  1=write, 0=read.
REQ-012 dm_addr  input  ADDR_W  data address.
REQ-013 dm_wdata  input  DATA_W  write data.
REQ-014 dm_rdata  output  DATA_W  read data; valid when dm_valid=1.
REQ-015 dm_valid  output  1  one-cycle completion pulse, for reads and writes.
REQ-016 drain  input  1  when 1, no new grants; in-flight access completes (driven from cpu halt path).
REQ-017 quiesced  output  1  1 when state is IDLE and drain=1.
REQ-018 mem_en  output  1  one-cycle access strobe to unified single-port memory.
REQ-019 mem_wr  output  1  write qualifier, valid with mem_en.
REQ-020 mem_addr, mem_wdata  output  ADDR_W/DATA_W  registered access address/data, held through ACCESS.
REQ-021 mem_rdata  input  DATA_W  memory read data, valid exactly MEM_LAT cycles after mem_en.

Function
REQ-022 FSM states IDLE, ACCESS, RESP; only one access in flight at any time.
REQ-023 IDLE: if drain=0 and any req, register grant, owner, address, wr, wdata; next state ACCESS; else stay IDLE.
REQ-024 Arbitration on simultaneous if_req and dm_req: dm wins unless previous grant was dm, then if wins (alternate on conflict); a lone requester always wins.
REQ-025 Last-grant flag updates only on grant; reset value = if (so first conflict goes to dm).
REQ-026 First ACCESS cycle: mem_en=1 for exactly one cycle; counter loads MEM_LAT and decrements each cycle.
REQ-027 When counter reaches 0, mem_rdata captured into owner's rdata register (reads only); next state RESP.
REQ-028 Writes follow identical timing; rdata registers unchanged by writes.
REQ-029 RESP: owner's valid=1 for one cycle; next state IDLE; requests are not sampled in RESP.
REQ-030 Timing: req sampled in IDLE at cycle 0 -> mem_en cycle 1 -> capture cycle 1+MEM_LAT -> valid cycle 2+MEM_LAT -> IDLE cycle 3+MEM_LAT.
REQ-031 if_rdata/dm_rdata hold last captured value until next capture for that port.
REQ-032 Losing requester stays pending; served at next IDLE sample if still requesting and drain=0.
REQ-033 drain asserted mid-access: no effect until IDLE; then no grant, quiesced=1.
REQ-034 if_valid and dm_valid never both 1; mem_en never asserted outside first ACCESS cycle.

Reset
REQ-035 rst=1 at a clock edge forces IDLE, counter 0, last-grant=if, all outputs and data registers 0, regardless of state.
REQ-036 Reset mid-ACCESS aborts the access; late mem_rdata is discarded; no valid pulse issued.

Structure
REQ-037 Shared package cpu_pkg holds ADDR_W, DATA_W, MEM_LAT defaults and the arbiter state enum.
REQ-038 One sub-module, lat_counter (loadable down-counter with zero flag), instantiated once.

Verification (MEM_LAT=4)
REQ-039 if_req alone, if_addr=0x0010, memory returns 0xA5A5 -> mem_en cycle 1, if_valid cycle 6 with if_rdata=0xA5A5, IDLE cycle 7.
REQ-040 if_req and dm_req (read 0x2000) at cycle 0 -> dm granted first, dm_valid cycle 6; if granted cycle 7, if_valid cycle 13.
REQ-041 Continuous conflict for 4 grants -> order dm, if, dm, if; never two consecutive dm grants while if pending.
REQ-042 dm write 0x1234 to 0x0040 -> mem_wr=1 with mem_en cycle 1, dm_valid cycle 6, dm_rdata unchanged.
REQ-043 rst pulsed at cycle 3 of a read -> no valid pulse, all outputs 0 next cycle, new request accepted after reset deasserts.
REQ-044 drain=1 at cycle 2 of a read with if_req pending -> dm_valid delivered, then quiesced=1, no further mem_en until drain=0.
